// File: rtl/ss_seq_pkg.sv
// Shared types and constants for the save-state sequencer.
package ss_seq_pkg;

    localparam int SS_ADDR_W = 8;
    localparam int SS_DAT_W  = 8;

    // Slot in the state address space that holds the mapper index.
    localparam int SS_MAP_IDX_SLOT = 127;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_CAP,
        S_MWR,
        S_MRD,
        S_STRB_HI,
        S_STRB_LO,
        S_NEXT,
        S_DONE
    } ss_state_e;

endpackage

// File: rtl/ss_m2_gen.sv
// Strobe generator: while go is held, m2 is high for M2_HALF cycles and then low
// for M2_HALF cycles; fin pulses on the last cycle of each half.
module ss_m2_gen #(
    parameter int M2_HALF = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic go_i,
    output logic m2_o,
    output logic fin_o
);

    localparam int CW = (M2_HALF > 1) ? $clog2(M2_HALF) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(M2_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          low_q, low_d;

    always_comb begin
        cnt_d = RELOAD;
        low_d = 1'b0;
        fin_o = 1'b0;
        if (go_i) begin
            cnt_d = cnt_q - CW'(1);
            low_d = low_q;
            if (cnt_q == '0) begin
                fin_o = 1'b1;
                cnt_d = RELOAD;
                low_d = ~low_q;
            end
        end
    end

    // Gated by go so the strobe drops in the same cycle the sequencer leaves the strobe states.
    assign m2_o = go_i & ~low_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= RELOAD;
            low_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            low_q <= low_d;
        end
    end

endmodule

// File: rtl/ss_seq.sv
// Save-state sequencer: walks the mapper state addresses, copying each byte to
// state memory (save) or replaying memory bytes into the mapper via ss_m2 (load).
module ss_seq
    import ss_seq_pkg::*;
#(
    parameter int REG_CNT = 128,
    parameter int SETTLE  = 2,
    parameter int M2_HALF = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 dir,
    output logic                 busy,
    output logic                 done,
    output logic                 ss_act,
    output logic                 ss_we,
    output logic [SS_ADDR_W-1:0] ss_addr,
    output logic [SS_DAT_W-1:0]  ss_wdat,
    output logic                 ss_m2,
    input  logic [SS_DAT_W-1:0]  ss_rdat,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [SS_ADDR_W-1:0] mem_addr,
    output logic [SS_DAT_W-1:0]  mem_wdat,
    input  logic [SS_DAT_W-1:0]  mem_rdat,
    input  logic                 mem_ack,
    output ss_state_e            dbg_state_o
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    // Nine bits so that REG_CNT=256 reaches its last address without wrapping.
    localparam logic [8:0] LAST_ADDR = 9'(REG_CNT - 1);

    ss_state_e               state_q, state_d;
    logic [8:0]              addr_q, addr_d;
    logic                    dir_q, dir_d;
    logic [SW-1:0]           settle_q, settle_d;
    logic [SS_DAT_W-1:0]     cap_q, cap_d;
    logic [SS_DAT_W-1:0]     ldat_q, ldat_d;
    logic                    strb_go;
    logic                    strb_fin;

    assign strb_go = (state_q == S_STRB_HI) || (state_q == S_STRB_LO);

    ss_m2_gen #(.M2_HALF(M2_HALF)) u_m2 (
        .clk_i (clk),
        .rst_i (rst),
        .go_i  (strb_go),
        .m2_o  (ss_m2),
        .fin_o (strb_fin)
    );

    // Memory handshake: mem_req is held with stable mem_we/addr/wdat until a cycle
    // with mem_ack high; that cycle completes the access and mem_req drops next cycle.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        dir_d    = dir_q;
        settle_d = settle_q;
        cap_d    = cap_q;
        ldat_d   = ldat_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = '0;
                    dir_d    = dir;
                    settle_d = '0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = dir_q ? S_MRD : S_CAP;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_CAP: begin
                cap_d   = ss_rdat;
                state_d = S_MWR;
            end
            S_MWR: begin
                if (mem_ack) state_d = S_NEXT;
            end
            S_MRD: begin
                if (mem_ack) begin
                    ldat_d  = mem_rdat;
                    state_d = S_STRB_HI;
                end
            end
            S_STRB_HI: begin
                if (strb_fin) state_d = S_STRB_LO;
            end
            S_STRB_LO: begin
                if (strb_fin) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    addr_d   = addr_q + 9'd1;
                    settle_d = '0;
                    state_d  = S_SETUP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            dir_q    <= 1'b0;
            settle_q <= '0;
            cap_q    <= '0;
            ldat_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            dir_q    <= dir_d;
            settle_q <= settle_d;
            cap_q    <= cap_d;
            ldat_q   <= ldat_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign ss_act      = busy;
    assign done        = (state_q == S_DONE);
    assign ss_we       = strb_go;
    assign ss_addr     = addr_q[SS_ADDR_W-1:0];
    assign ss_wdat     = ldat_q;
    assign mem_req     = (state_q == S_MWR) || (state_q == S_MRD);
    assign mem_we      = (state_q == S_MWR);
    assign mem_addr    = ss_addr;
    assign mem_wdat    = cap_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ss_seq.sv
// Bench for ss_seq: three instances (REG_CNT 4, 2, 256) share a memory/mapper model;
// table-driven passes plus hand-written reset and ignored-start sequences.
module tb_ss_seq;
    import ss_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start_v = '0;
    logic       dir = 1'b0;

    logic [2:0] busy_v, done_v, act_v, we_v, m2_v, req_v, mwe_v;
    logic [7:0] addr_v [3];
    logic [7:0] wdat_v [3];
    logic [7:0] maddr_v [3];
    logic [7:0] mwdat_v [3];
    ss_state_e  state_v [3];

    logic [7:0] ss_rdat, mem_rdat;
    logic       mem_ack = 1'b0;

    int         sel = 0;
    logic       busy, done, ss_act, ss_we, ss_m2, mem_req, mem_we;
    logic [7:0] ss_addr, ss_wdat, mem_addr, mem_wdat;
    ss_state_e  state;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int RC = (g == 0) ? 4 : (g == 1) ? 2 : 256;
        ss_seq #(.REG_CNT(RC)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start_v[g]),
            .dir         (dir),
            .busy        (busy_v[g]),
            .done        (done_v[g]),
            .ss_act      (act_v[g]),
            .ss_we       (we_v[g]),
            .ss_addr     (addr_v[g]),
            .ss_wdat     (wdat_v[g]),
            .ss_m2       (m2_v[g]),
            .ss_rdat     (ss_rdat),
            .mem_req     (req_v[g]),
            .mem_we      (mwe_v[g]),
            .mem_addr    (maddr_v[g]),
            .mem_wdat    (mwdat_v[g]),
            .mem_rdat    (mem_rdat),
            .mem_ack     (mem_ack),
            .dbg_state_o (state_v[g])
        );
    end

    always_comb begin
        busy     = busy_v[sel];
        done     = done_v[sel];
        ss_act   = act_v[sel];
        ss_we    = we_v[sel];
        ss_m2    = m2_v[sel];
        mem_req  = req_v[sel];
        mem_we   = mwe_v[sel];
        ss_addr  = addr_v[sel];
        ss_wdat  = wdat_v[sel];
        mem_addr = maddr_v[sel];
        mem_wdat = mwdat_v[sel];
        state    = state_v[sel];
    end

    // ---------------- models and scoreboard ----------------
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  mem [256];
    logic [7:0]  map_reg [256];
    logic [15:0] exp_q [$];
    int          ack_lat = 0;
    int          req_len = 0;
    int          req_cnt, req_bad, req_unstable, done_cnt, we_cnt, falls;
    logic [16:0] req_snap;
    logic [7:0]  last_waddr;

    assign ss_rdat  = ss_addr ^ 8'h5A;
    assign mem_rdat = mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_req) begin
            if (req_len == 0) req_snap = {mem_we, mem_addr, mem_wdat};
            else if ({mem_we, mem_addr, mem_wdat} !== req_snap) req_unstable++;
            req_len++;
            if (req_len == ack_lat + 1) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdat;
                    last_waddr = mem_addr;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_extra_write: got %h, expected no write", {mem_addr, mem_wdat});
                    end else begin
                        check("sb_write", {16'h0, mem_addr, mem_wdat}, {16'h0, exp_q.pop_front()});
                    end
                end
            end
        end else if (req_len != 0) begin
            req_cnt++;
            if (req_len != ack_lat + 1) req_bad++;
            req_len = 0;
        end
        if (done) done_cnt++;
        if (ss_we) we_cnt++;
    end

    // Mapper model: latches ss_wdat on the falling edge of the private strobe.
    always @(negedge ss_m2) begin
        falls++;
        if (ss_we) map_reg[ss_addr] = ss_wdat;
    end

    // ---------------- driver tasks ----------------
    function automatic int reg_cnt_of(input int s);
        return (s == 0) ? 4 : (s == 1) ? 2 : 256;
    endfunction

    task automatic prep(input int s, input logic d, input int lat);
        int n;
        n = reg_cnt_of(s);
        sel = s;
        ack_lat = lat;
        dir = d;
        exp_q.delete();
        done_cnt = 0; we_cnt = 0; falls = 0;
        req_cnt = 0; req_bad = 0; req_unstable = 0;
        last_waddr = '0;
        for (int a = 0; a < 256; a++) map_reg[a] = '0;
        for (int a = 0; a < n; a++) begin
            logic [7:0] a8;
            a8 = 8'(a);
            if (d) mem[a] = 8'(8'h11 * (a + 1));
            else exp_q.push_back({a8, a8 ^ 8'h5A});
        end
    endtask

    task automatic pulse_start();
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
    endtask

    typedef struct {
        int   sel;
        logic dir;
        int   lat;
        int   exp_cycles;
        int   exp_falls;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        int cyc;
        bit seen;
        n = reg_cnt_of(v.sel);
        cyc = 0;
        seen = 0;
        prep(v.sel, v.dir, v.lat);
        pulse_start();
        check($sformatf("v%0d_first_state", idx), 32'(state), 32'(S_SETUP));
        check($sformatf("v%0d_first_addr", idx), 32'(ss_addr), 32'h0);
        for (int i = 0; i < 5000 && !seen; i++) begin
            if (busy) cyc++;
            if (done) seen = 1;
            else @(negedge clk);
        end
        check($sformatf("v%0d_done_seen", idx), 32'(seen), 32'h1);
        check($sformatf("v%0d_busy_cycles", idx), cyc, v.exp_cycles);
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_done_pulses", idx), done_cnt, 1);
        check($sformatf("v%0d_idle_state", idx), 32'(state), 32'(S_IDLE));
        check($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'h0);
        check($sformatf("v%0d_m2_falls", idx), falls, v.exp_falls);
        check($sformatf("v%0d_we_cycles", idx), we_cnt, v.dir ? n * 8 : 0);
        check($sformatf("v%0d_req_count", idx), req_cnt, n);
        check($sformatf("v%0d_req_len_bad", idx), req_bad, 0);
        check($sformatf("v%0d_req_unstable", idx), req_unstable, 0);
        check($sformatf("v%0d_sb_left", idx), exp_q.size(), 0);
        if (!v.dir) check($sformatf("v%0d_last_waddr", idx), 32'(last_waddr), 32'(n - 1));
        else begin
            for (int a = 0; a < n; a++)
                check($sformatf("v%0d_map_reg%0d", idx, a), 32'(map_reg[a]), 32'(8'(8'h11 * (a + 1))));
        end
    endtask

    // ---------------- test ----------------
    vec_t vecs [7];

    initial begin
        int  cyc;
        int  extra;
        bit  seen;

        vecs[0] = '{0, 1'b0, 0, 21, 0};
        vecs[1] = '{0, 1'b1, 0, 49, 4};
        vecs[2] = '{1, 1'b0, 5, 21, 0};
        vecs[3] = '{1, 1'b1, 5, 35, 2};
        vecs[4] = '{0, 1'b0, 2, 29, 0};
        vecs[5] = '{0, 1'b1, 1, 53, 4};
        vecs[6] = '{2, 1'b0, 0, 1281, 0};

        repeat (3) @(negedge clk);
        check("rst_ctrl", 32'({busy, done, ss_act, ss_we, ss_m2, mem_req, mem_we}), 32'h0);
        check("rst_data", {ss_addr, ss_wdat, mem_addr, mem_wdat}, 32'h0);
        check("rst_state", 32'(state), 32'(S_IDLE));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Start while busy, and start coincident with done, are both ignored.
        prep(0, 1'b0, 0);
        pulse_start();
        cyc = 0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (busy) cyc++;
            if (done) seen = 1;
            else begin
                start_v[0] = (i == 3);
                @(negedge clk);
            end
        end
        check("ign_done_seen", 32'(seen), 32'h1);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        check("ign_busy_after_done", 32'(busy), 32'h0);
        check("ign_state_after_done", 32'(state), 32'(S_IDLE));
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) extra++;
        end
        check("ign_busy_cycles", cyc, 21);
        check("ign_no_restart", extra, 0);
        check("ign_done_pulses", done_cnt, 1);
        check("ign_sb_left", exp_q.size(), 0);

        // Reset during the third STRB_HI of a load.
        prep(0, 1'b1, 0);
        pulse_start();
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (state == S_STRB_HI && ss_addr == 8'd2) seen = 1;
            else @(negedge clk);
        end
        check("mid_reach_strb3", 32'(seen), 32'h1);
        check("mid_m2_high", 32'(ss_m2), 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_ctrl", 32'({busy, done, ss_act, ss_we, ss_m2, mem_req, mem_we}), 32'h0);
        check("mid_rst_data", {ss_addr, ss_wdat, mem_addr, mem_wdat}, 32'h0);
        check("mid_rst_state", 32'(state), 32'(S_IDLE));
        @(negedge clk);
        check("mid_rst_ctrl_next", 32'({busy, done, ss_act, ss_we, ss_m2, mem_req, mem_we}), 32'h0);
        check("mid_rst_state_next", 32'(state), 32'(S_IDLE));
        rst = 1'b0;
        @(negedge clk);
        run_vec(vecs[1], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
